// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_en;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic [DATA_W-1:0]   m_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata, m_be,
    input  m_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_be,
    output m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF / load-store arbiter onto one memory port with in-order read return.
// MEM_ARB_ROUND_ROBIN_EN swaps D priority + starvation guard for round robin.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  logic              if_win;
  logic              if_gnt;
  logic              d_gnt;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_q, own_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = D won the most recent grant
  logic last_d_q, last_d_d;

  always_comb begin
    if_win   = bus.if_req & (~bus.d_req | last_d_q);
    last_d_d = last_d_q;
    if (d_gnt)
      last_d_d = 1'b1;
    else if (if_gnt)
      last_d_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  always_comb begin
    starved  = (starve_q == CNT_W'(STARVE_MAX));
    if_win   = bus.if_req & (~bus.d_req | starved);
    starve_d = '0;
    if (bus.if_req & ~if_gnt)
      starve_d = starved ? starve_q : starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`endif

  // Grants are forced low while reset is held
  assign if_gnt = if_win & ~rst;
  assign d_gnt  = bus.d_req & ~if_win & ~rst;

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    unique case (1'b1)
      if_gnt: begin
        m_en   = 1'b1;
        m_addr = bus.if_addr;
        m_be   = '1;
      end
      d_gnt: begin
        m_en    = 1'b1;
        m_we    = bus.d_we;
        m_addr  = bus.d_addr;
        m_wdata = bus.d_wdata;
        m_be    = bus.d_be;
      end
      default: ;
    endcase
  end

  // own = 1 marks an IF read
  always_comb begin
    vld_d    = vld_q;
    own_d    = own_q;
    vld_d[0] = m_en & ~m_we;
    own_d[0] = if_gnt;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  logic if_rv, d_rv;

  assign if_rv = vld_q[RD_LAT-1] & own_q[RD_LAT-1];
  assign d_rv  = vld_q[RD_LAT-1] & ~own_q[RD_LAT-1];

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rv;
  assign bus.d_rvalid  = d_rv;
  assign bus.if_rdata  = if_rv ? bus.m_rdata : '0;
  assign bus.d_rdata   = d_rv ? bus.m_rdata : '0;
  assign bus.m_en      = m_en;
  assign bus.m_we      = m_we;
  assign bus.m_addr    = m_addr;
  assign bus.m_wdata   = m_wdata;
  assign bus.m_be      = m_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency memory model.
// Builds either arbitration mode via MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] a;
    a = 32'(i);
    return (a * 32'h9E37_79B9) ^ 32'h0000_1357;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                       input logic [31:0] n,
                                       input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Memory model, driven only from the DUT memory port
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [LAT-1:0] mv;
  logic [31:0]    md [LAT];

  initial
    for (int i = 0; i < 256; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv <= '0;
    end else begin
      mv    <= {mv[LAT-2:0], bus.m_en & ~bus.m_we};
      md[0] <= mem[bus.m_addr[9:2]];
      for (int i = 1; i < LAT; i++) md[i] <= md[i-1];
      if (bus.m_en & bus.m_we)
        mem[bus.m_addr[9:2]] <=
          merge(mem[bus.m_addr[9:2]], bus.m_wdata, bus.m_be);
    end
  end

  assign bus.m_rdata = mv[LAT-1] ? md[LAT-1] : 32'hBAD0_0BAD;

  typedef struct {
    logic        own_if;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];

  // Arbitration reference state
  int   scnt   = 0;
  logic last_d = 1'b0;

  always @(negedge clk) begin : mon
    logic        due, eif, ed;
    logic [31:0] dat;
    if (!rst) begin
      due = (q.size() > 0) && (q[0].due == cyc);
      eif = due && q[0].own_if;
      ed  = due && !q[0].own_if;
      dat = due ? q[0].data : 32'h0;
      if (due || bus.if_rvalid || bus.d_rvalid) begin
        check("if_rvalid", 32'(bus.if_rvalid), 32'(eif));
        check("d_rvalid", 32'(bus.d_rvalid), 32'(ed));
        check("if_rdata", bus.if_rdata, eif ? dat : 32'h0);
        check("d_rdata", bus.d_rdata, ed ? dat : 32'h0);
      end
      if (due) void'(q.pop_front());
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd,
                       input logic [3:0] db,
                       output logic gi, output logic gd);
    logic win_if;
    exp_t e;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
    bus.d_be    = db;
    #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    win_if = ir && (!dr || last_d);
`else
    win_if = ir && (!dr || scnt == SMAX);
`endif
    gi = win_if;
    gd = dr && !win_if;
    check("if_gnt", 32'(bus.if_gnt), 32'(gi));
    check("d_gnt", 32'(bus.d_gnt), 32'(gd));
    check("one_gnt", 32'(bus.if_gnt & bus.d_gnt), 32'h0);
    check("m_en", 32'(bus.m_en), 32'(gi | gd));
    if (gi) begin
      check("m_addr_if", bus.m_addr, ia);
      check("m_we_if", 32'(bus.m_we), 32'h0);
      check("m_be_if", 32'(bus.m_be), 32'hF);
      e.own_if = 1'b1;
      e.data   = ref_mem[ia[9:2]];
      e.due    = cyc + LAT;
      q.push_back(e);
    end else if (gd) begin
      check("m_addr_d", bus.m_addr, da);
      check("m_we_d", 32'(bus.m_we), 32'(dw));
      check("m_be_d", 32'(bus.m_be), 32'(db));
      if (dw) begin
        check("m_wdata", bus.m_wdata, dd);
        ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], dd, db);
      end else begin
        e.own_if = 1'b0;
        e.data   = ref_mem[da[9:2]];
        e.due    = cyc + LAT;
        q.push_back(e);
      end
    end else begin
      check("idle_addr", bus.m_addr, 32'h0);
      check("idle_misc", {27'h0, bus.m_we, bus.m_be}, 32'h0);
      check("idle_wdata", bus.m_wdata, 32'h0);
    end
    if (ir && !win_if) scnt = (scnt == SMAX) ? SMAX : scnt + 1;
    else               scnt = 0;
    if (gd)      last_d = 1'b1;
    else if (gi) last_d = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic gi, gd;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, gi, gd);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'h0);
    check({tag, "_d_gnt"}, 32'(bus.d_gnt), 32'h0);
    check({tag, "_m_en"}, 32'(bus.m_en), 32'h0);
    check({tag, "_rvalid"}, {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
    check({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    check({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
  endtask

  initial begin : main
    logic gi, gd;
    logic pi, pd, pw;
    logic [31:0] pia, pda, pdd;
    logic [3:0]  pbe;

    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h80;
    bus.d_wdata = 32'h0;
    bus.d_be    = 4'h0;
    @(negedge clk);
    reset_check("rst");
    @(negedge clk);
    rst = 1'b0;

    // Single IF read
    drive(1, 32'h10, 0, 0, 0, 0, 0, gi, gd);
    idle(LAT + 1);

    // Contention: D wins until the IF starvation guard fires
    for (int i = 0; i < 12; i++)
      drive(1, 32'h20, 1, 0, 32'h30 + 32'(4 * i), 0, 4'hF, gi, gd);
    idle(LAT + 1);

    // Back-to-back mixed reads
    drive(0, 0, 1, 0, 32'h100, 0, 4'hF, gi, gd);
    drive(1, 32'h4, 0, 0, 0, 0, 0, gi, gd);
    drive(0, 0, 1, 0, 32'h104, 0, 4'hF, gi, gd);
    idle(LAT + 1);

    // Partial write then read back
    drive(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011, gi, gd);
    drive(0, 0, 1, 0, 32'h200, 0, 4'hF, gi, gd);
    idle(LAT + 1);

    // Random traffic, each requester holding until granted
    pi = 0; pd = 0; pw = 0;
    pia = 0; pda = 0; pdd = 0; pbe = 0;
    for (int i = 0; i < 60; i++) begin
      if (!pi) begin
        pi  = 1'($urandom_range(0, 1));
        pia = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!pd) begin
        pd  = 1'($urandom_range(0, 1));
        pw  = 1'($urandom_range(0, 1));
        pda = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        pdd = $urandom;
        pbe = 4'($urandom_range(1, 15));
      end
      drive(pi, pia, pd, pw, pda, pdd, pbe, gi, gd);
      if (gi) pi = 0;
      if (gd) pd = 0;
    end
    idle(LAT + 1);
    check("drain1", 32'(q.size()), 32'h0);

    // Reset while an IF read is in flight
    drive(1, 32'h44, 0, 0, 0, 0, 0, gi, gd);
    rst         = 1'b1;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    #1;
    reset_check("midrst");
    q.delete();
    scnt   = 0;
    last_d = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_check("midrst_hold");
    rst = 1'b0;

    // Requests held through reset are evaluated right after it
    drive(1, 32'h48, 1, 0, 32'h88, 0, 4'hF, gi, gd);
    drive(1, 32'h48, 0, 0, 0, 0, 0, gi, gd);
    idle(LAT + 2);
    check("drain2", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory/peripheral port between two requesters: the core's instruction-fetch (IF) port and its load/store (D) port.
- Issues at most one transaction per cycle to the memory side.
- Tracks outstanding reads through a latency pipeline and routes each returned word to the requester that issued it.
- Sits between riscv_core and perip, so IF and data traffic can target one unified memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- RD_LAT, 1, memory read latency in cycles (legal range 1..4).
- STARVE_MAX, 4, maximum consecutive cycles an IF request may lose before it is forced to win.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  IF read request.
- if_addr  in  ADDR_W  IF address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DATA_W  IF read data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid.
- d_rdata  out  DATA_W  data read data.
- m_en  out  1  memory transaction strobe.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_be  out  DATA_W/8  memory byte enables.
- m_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read strobe.

Behaviour:
- Acceptance:
  - A request is accepted when req and gnt are both high at a rising clk edge.
  - gnt is combinational from req and the arbiter state.
  - The requester holds req, addr and wdata stable until it sees gnt.
  - At most one of if_gnt / d_gnt is high in any cycle.
- Memory side:
  - m_en = if_gnt | d_gnt; m_* fields are muxed from the winning requester.
  - IF transactions drive m_we = 0 and m_be = all ones.
  - When idle: m_en = 0, m_we = 0, m_addr = 0, m_wdata = 0, m_be = 0.
- Default priority: D beats IF whenever both request.
- Starvation counter (starve_cnt):
  - Increments on every cycle where if_req = 1 and if_gnt = 0.
  - Clears on if_gnt or when if_req = 0.
  - When starve_cnt == STARVE_MAX, IF wins regardless of d_req and the counter clears.
  - The counter saturates at STARVE_MAX.
- Response pipeline:
  - Shift register of RD_LAT stages, each holding {valid, owner}.
  - An accepted read enters stage 0 with owner = IF or D; writes enter valid = 0.
  - When the last stage is valid, the owner's rvalid is high for exactly one cycle and its rdata = m_rdata.
  - A non-owner's rdata, and any rdata while rvalid = 0, is 0.
  - Reads may issue back-to-back every cycle; responses return in issue order, with no bubbles added by the arbiter.
- Writes produce no rvalid; completion is signalled by d_gnt.
- Simultaneous events:
  - A new grant and a returning response in the same cycle are independent and both occur.
  - IF and D responses can never coincide, because only one transaction issues per cycle.
- Reset: asynchronous assertion clears the pipeline valids, starve_cnt and the RR pointer.
  - Outputs during reset: gnt = 0, rvalid = 0, rdata = 0, m_en = 0.
  - Reads in flight at reset are dropped; no rvalid appears for them after reset deasserts.
- Requests presented during reset are not granted; they are evaluated normally on the first cycle after deassertion.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN
- When defined:
  - Fixed D priority is replaced by a 1-bit last-winner pointer, reset to "IF last".
  - On contention, the requester that did not win last time wins; the pointer updates on every grant.
  - The starvation counter logic is removed, and STARVE_MAX is ignored.
- When undefined: fixed D priority plus the starvation counter, as specified above.

Test Plan:
- Single IF read, RD_LAT=1: if_req=1, if_addr=0x10, m_rdata=0x00000013 next cycle -> if_gnt=1 at cycle 0, m_en=1, m_addr=0x10; if_rvalid=1 with if_rdata=0x13 at cycle 1; d_rvalid stays 0.
- Contention, fixed priority: if_req and d_req both held high, d_we=0, STARVE_MAX=4 -> d_gnt for 4 cycles, then if_gnt in cycle 5, then d_gnt resumes; no cycle has both grants.
- Back-to-back mixed reads, RD_LAT=3: accept D@0x100, IF@0x4, D@0x104 in consecutive cycles -> rvalids arrive at cycles 3, 4, 5 in the order D, IF, D, each carrying the m_rdata of its cycle.
- Write then read: D write 0xDEADBEEF to 0x200 with d_be=4'b0011 -> m_we=1, m_be=4'b0011, m_wdata=0xDEADBEEF, no d_rvalid; a following D read of 0x200 returns d_rvalid after RD_LAT.
- Reset mid-flight, RD_LAT=2: issue an IF read, then assert rst one cycle later -> all outputs 0 immediately; after deassertion, if_rvalid never pulses for the dropped read.
- With MEM_ARB_ROUND_ROBIN_EN defined: both requesters held high for 6 cycles -> grants alternate D, IF, D, IF, D, IF starting with D.
